// File: rtl/eth_sink_pkg.sv
// Shared types and defaults for the frame-aware Ethernet receive sink.
// The ETH_SINK_STATS_EN build option is handled in the top, not here.
package eth_sink_pkg;

   localparam int DATA_W_DFLT = 32;
   localparam int MOD_W_DFLT  = 2;
   localparam int RX_ERR_W    = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } sink_state_e;

   // Entry layout at the default widths; the top packs the same field order
   // {data, sop, eop, mod} into a flat vector so DATA_W/MOD_W stay generic.
   typedef struct packed {
      logic [DATA_W_DFLT-1:0] data;
      logic                   sop;
      logic                   eop;
      logic [MOD_W_DFLT-1:0]  mod;
   } sink_entry_t;

   function automatic int entry_w(input int data_w, input int mod_w);
      return data_w + mod_w + 2;
   endfunction

endpackage

// File: rtl/sink_fifo_mem.sv
// DEPTH x W entry array for the receive sink: one synchronous write port,
// one combinational read port, no reset (validity is tracked by the pointers).
module sink_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int W     = 36
) (
   input  logic                     clk_hifreq,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_hifreq) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/eth_rx_frame_sink.sv
// Store-and-forward Avalon-ST receive sink: only whole good frames reach the output.
// Define ETH_SINK_STATS_EN to build the frame/err/drop counters and hdr_word register.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | between frames; a sop beat starts a frame, other beats dropped
//   ST_RECV | frame in progress, beats written speculatively past cm_ptr
//   ST_DROP | frame abandoned (overflow); discard beats until eop
module eth_rx_frame_sink
   import eth_sink_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int MOD_W  = MOD_W_DFLT,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16
) (
   input  logic                clk_hifreq,
   input  logic                rst,
   input  logic [DATA_W-1:0]   ff_rx_data,
   input  logic                ff_rx_dval,
   input  logic                ff_rx_sop,
   input  logic                ff_rx_eop,
   input  logic [MOD_W-1:0]    ff_rx_mod,
   input  logic [RX_ERR_W-1:0] rx_err,
   output logic                ff_rx_rdy,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_sop,
   output logic                out_eop,
   output logic [MOD_W-1:0]    out_mod,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   hdr_word,
   input  logic                stats_clr,
   output logic [CNT_W-1:0]    frame_cnt,
   output logic [CNT_W-1:0]    err_cnt,
   output logic [CNT_W-1:0]    drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = entry_w(DATA_W, MOD_W);
   localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   sink_state_e   state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] cm_ptr_q, cm_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_fill, cm_fill;
   logic          fifo_full, cm_full;
   logic          beat_acc, out_xfer;
   logic          inc_frame, inc_err, inc_drop;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [EW-1:0] mem_wdata, mem_rdata;

   assign wr_fill   = wr_ptr_q - rd_ptr_q;
   assign cm_fill   = cm_ptr_q - rd_ptr_q;
   assign fifo_full = (wr_fill == PTR_DEPTH);
   assign cm_full   = (cm_fill == PTR_DEPTH);

   assign ff_rx_rdy = (state_q != ST_RECV) || !cm_full;
   assign beat_acc  = ff_rx_dval && ff_rx_rdy;
   assign mem_wdata = {ff_rx_data, ff_rx_sop, ff_rx_eop, ff_rx_mod};

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      cm_ptr_d  = cm_ptr_q;
      mem_we    = 1'b0;
      mem_waddr = wr_ptr_q[AW-1:0];
      inc_frame = 1'b0;
      inc_err   = 1'b0;
      inc_drop  = 1'b0;
      case (state_q)
         ST_IDLE, ST_RECV: begin
            if (beat_acc) begin
               if (ff_rx_sop) begin
                  // A new frame always starts at cm_ptr; in RECV this discards the unterminated one.
                  if (state_q == ST_RECV) begin
                     inc_drop = 1'b1;
                  end
                  wr_ptr_d  = cm_ptr_q;
                  mem_waddr = cm_ptr_q[AW-1:0];
                  if (ff_rx_eop && (rx_err != '0)) begin
                     inc_err = 1'b1;
                     state_d = ST_IDLE;
                  end else if (cm_full) begin
                     inc_drop = 1'b1;
                     state_d  = ff_rx_eop ? ST_IDLE : ST_DROP;
                  end else begin
                     mem_we   = 1'b1;
                     wr_ptr_d = cm_ptr_q + PTR_ONE;
                     if (ff_rx_eop) begin
                        cm_ptr_d  = cm_ptr_q + PTR_ONE;
                        inc_frame = 1'b1;
                        state_d   = ST_IDLE;
                     end else begin
                        state_d = ST_RECV;
                     end
                  end
               end else if (state_q == ST_IDLE) begin
                  inc_drop = 1'b1;
               end else if (ff_rx_eop && (rx_err != '0)) begin
                  wr_ptr_d = cm_ptr_q;
                  inc_err  = 1'b1;
                  state_d  = ST_IDLE;
               end else if (fifo_full) begin
                  wr_ptr_d = cm_ptr_q;
                  inc_drop = 1'b1;
                  state_d  = ff_rx_eop ? ST_IDLE : ST_DROP;
               end else begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (ff_rx_eop) begin
                     cm_ptr_d  = wr_ptr_q + PTR_ONE;
                     inc_frame = 1'b1;
                     state_d   = ST_IDLE;
                  end
               end
            end
         end
         ST_DROP: begin
            if (beat_acc && ff_rx_eop) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign out_valid = (cm_fill != '0);
   assign out_xfer  = out_valid && out_ready;
   assign rd_ptr_d  = out_xfer ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

   // Gating by out_valid keeps the outputs at 0 whenever nothing committed is readable.
   assign {out_data, out_sop, out_eop, out_mod} = out_valid ? mem_rdata : '0;

   always_ff @(posedge clk_hifreq or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         cm_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         cm_ptr_q <= cm_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   sink_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_mem (
      .clk_hifreq (clk_hifreq),
      .we         (mem_we),
      .waddr      (mem_waddr),
      .wdata      (mem_wdata),
      .raddr      (rd_ptr_q[AW-1:0]),
      .rdata      (mem_rdata)
   );

`ifdef ETH_SINK_STATS_EN
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [DATA_W-1:0] hdr_q, hdr_d;
   logic [DATA_W-1:0] first_q, first_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != '1)) begin
         return v + CNT_W'(1);
      end
      return v;
   endfunction

   always_comb begin
      frame_cnt_d = sat_inc(frame_cnt_q, inc_frame);
      err_cnt_d   = sat_inc(err_cnt_q, inc_err);
      drop_cnt_d  = sat_inc(drop_cnt_q, inc_drop);
      if (stats_clr) begin
         frame_cnt_d = '0;
         err_cnt_d   = '0;
         drop_cnt_d  = '0;
      end
      first_d = first_q;
      if (beat_acc && ff_rx_sop && (state_q != ST_DROP)) begin
         first_d = ff_rx_data;
      end
      hdr_d = hdr_q;
      if (inc_frame) begin
         hdr_d = ff_rx_sop ? ff_rx_data : first_q;
      end
   end

   always_ff @(posedge clk_hifreq or negedge rst) begin
      if (!rst) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         hdr_q       <= '0;
         first_q     <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         hdr_q       <= hdr_d;
         first_q     <= first_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign hdr_word  = hdr_q;
`else
   logic stats_unused;
   assign stats_unused = ^{stats_clr, inc_frame, inc_err, inc_drop};

   assign frame_cnt = '0;
   assign err_cnt   = '0;
   assign drop_cnt  = '0;
   assign hdr_word  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_sink.sv
// Directed self-checking bench for eth_rx_frame_sink (DATA_W=32, DEPTH=16, CNT_W=4).
// Counter and hdr_word expectations collapse to 0 when ETH_SINK_STATS_EN is undefined.
module tb_eth_rx_frame_sink;

   localparam int DATA_W = 32;
   localparam int MOD_W  = 2;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 4;
`ifdef ETH_SINK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] ff_rx_data;
   logic              ff_rx_dval;
   logic              ff_rx_sop;
   logic              ff_rx_eop;
   logic [MOD_W-1:0]  ff_rx_mod;
   logic [5:0]        rx_err;
   logic              ff_rx_rdy;
   logic [DATA_W-1:0] out_data;
   logic              out_sop;
   logic              out_eop;
   logic [MOD_W-1:0]  out_mod;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] hdr_word;
   logic              stats_clr;
   logic [CNT_W-1:0]  frame_cnt;
   logic [CNT_W-1:0]  err_cnt;
   logic [CNT_W-1:0]  drop_cnt;

   int          n_checks = 0;
   int          n_errors = 0;
   int          rdy_lows = 0;
   logic [35:0] got_q[$];
   logic [35:0] exp_q[$];

   eth_rx_frame_sink #(
      .DATA_W (DATA_W),
      .MOD_W  (MOD_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_hifreq (clk),
      .rst        (rst),
      .ff_rx_data (ff_rx_data),
      .ff_rx_dval (ff_rx_dval),
      .ff_rx_sop  (ff_rx_sop),
      .ff_rx_eop  (ff_rx_eop),
      .ff_rx_mod  (ff_rx_mod),
      .rx_err     (rx_err),
      .ff_rx_rdy  (ff_rx_rdy),
      .out_data   (out_data),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_mod    (out_mod),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .hdr_word   (hdr_word),
      .stats_clr  (stats_clr),
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output transfers are captured on the falling edge, half a cycle before the edge that takes them.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         got_q.push_back({out_sop, out_eop, out_mod, out_data});
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ec(input int v);
      return STATS ? 64'(v) : 64'd0;
   endfunction

   function automatic logic [35:0] item(input logic sop, input logic eop, input logic [1:0] m,
                                        input logic [31:0] d);
      return {sop, eop, m, d};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] d, input logic sop, input logic eop,
                       input logic [1:0] m, input logic [5:0] err);
      ff_rx_data = d;
      ff_rx_sop  = sop;
      ff_rx_eop  = eop;
      ff_rx_mod  = m;
      rx_err     = err;
      ff_rx_dval = 1'b1;
      if (!ff_rx_rdy) rdy_lows++;
      tick(1);
      ff_rx_dval = 1'b0;
      ff_rx_sop  = 1'b0;
      ff_rx_eop  = 1'b0;
      ff_rx_mod  = '0;
      rx_err     = '0;
   endtask

   task automatic compare_frames(input string tag);
      check_val({tag, " beat count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check_val($sformatf("%s beat %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      ff_rx_data = '0;
      ff_rx_dval = 1'b0;
      ff_rx_sop  = 1'b0;
      ff_rx_eop  = 1'b0;
      ff_rx_mod  = '0;
      rx_err     = '0;
      out_ready  = 1'b0;
      stats_clr  = 1'b0;
      tick(3);

      check_val("reset rdy", 64'(ff_rx_rdy), 64'd1);
      check_val("reset out_valid", 64'(out_valid), 64'd0);
      check_val("reset out_data", 64'(out_data), 64'd0);
      check_val("reset out_sop/eop/mod", 64'({out_sop, out_eop, out_mod}), 64'd0);
      check_val("reset hdr_word", 64'(hdr_word), 64'd0);
      check_val("reset counters", 64'({frame_cnt, err_cnt, drop_cnt}), 64'd0);
      rst = 1'b1;
      tick(2);

      // Good 4-beat frame, consumer always ready.
      out_ready = 1'b1;
      send(32'hA0, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'hA1, 1'b0, 1'b0, 2'd0, 6'd0);
      send(32'hA2, 1'b0, 1'b0, 2'd0, 6'd0);
      check_val("t1 valid before eop", 64'(out_valid), 64'd0);
      send(32'hA3, 1'b0, 1'b1, 2'd0, 6'd0);
      check_val("t1 valid after eop edge", 64'(out_valid), 64'd1);
      check_val("t1 first word", 64'({out_sop, out_data}), 64'({1'b1, 32'hA0}));
      exp_q.push_back(item(1'b1, 1'b0, 2'd0, 32'hA0));
      exp_q.push_back(item(1'b0, 1'b0, 2'd0, 32'hA1));
      exp_q.push_back(item(1'b0, 1'b0, 2'd0, 32'hA2));
      exp_q.push_back(item(1'b0, 1'b1, 2'd0, 32'hA3));
      tick(8);
      compare_frames("t1");
      check_val("t1 frame_cnt", 64'(frame_cnt), ec(1));
      check_val("t1 hdr_word", 64'(hdr_word), STATS ? 64'hA0 : 64'd0);

      // Errored frame is rewound.
      send(32'hB0, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'hB1, 1'b0, 1'b0, 2'd0, 6'd0);
      send(32'hB2, 1'b0, 1'b1, 2'd0, 6'h02);
      check_val("t2 valid after err eop", 64'(out_valid), 64'd0);
      tick(4);
      compare_frames("t2");
      check_val("t2 err_cnt", 64'(err_cnt), ec(1));
      check_val("t2 frame_cnt", 64'(frame_cnt), ec(1));

      // 20-beat frame overflows a 16-entry FIFO, then a 2-beat frame gets through.
      out_ready = 1'b0;
      rdy_lows  = 0;
      for (int i = 0; i < 20; i++) begin
         send(32'hC0 + 32'(i), i == 0, i == 19, 2'd0, 6'd0);
      end
      check_val("t3 rdy stayed high", 64'(rdy_lows), 64'd0);
      check_val("t3 drop_cnt", 64'(drop_cnt), ec(1));
      check_val("t3 nothing readable", 64'(out_valid), 64'd0);
      send(32'hD0, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'hD1, 1'b0, 1'b1, 2'd1, 6'd0);
      check_val("t3 follow-up valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      exp_q.push_back(item(1'b1, 1'b0, 2'd0, 32'hD0));
      exp_q.push_back(item(1'b0, 1'b1, 2'd1, 32'hD1));
      tick(4);
      compare_frames("t3");
      check_val("t3 frame_cnt", 64'(frame_cnt), ec(2));

      // Exactly DEPTH beats fit; a further frame while full is dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send(32'h100 + 32'(i), i == 0, i == 15, (i == 15) ? 2'd2 : 2'd0, 6'd0);
         exp_q.push_back(item(i == 0, i == 15, (i == 15) ? 2'd2 : 2'd0, 32'h100 + 32'(i)));
      end
      check_val("t3b full frame committed", 64'(out_valid), 64'd1);
      check_val("t3b frame_cnt", 64'(frame_cnt), ec(3));
      check_val("t3b hdr_word", 64'(hdr_word), STATS ? 64'h100 : 64'd0);
      check_val("t3b rdy while full idle", 64'(ff_rx_rdy), 64'd1);
      send(32'hEE, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'hEF, 1'b0, 1'b1, 2'd0, 6'd0);
      check_val("t3b drop_cnt", 64'(drop_cnt), ec(2));
      out_ready = 1'b1;
      tick(20);
      compare_frames("t3b");

      // Clear, stray beat in IDLE, then sop inside an unterminated frame.
      stats_clr = 1'b1;
      tick(1);
      stats_clr = 1'b0;
      check_val("t4 cleared", 64'({frame_cnt, err_cnt, drop_cnt}), 64'd0);
      send(32'h55, 1'b0, 1'b0, 2'd0, 6'd0);
      check_val("t4 stray drop", 64'(drop_cnt), ec(1));
      send(32'hE0, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'hE1, 1'b0, 1'b0, 2'd0, 6'd0);
      send(32'hF0, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'hF1, 1'b0, 1'b1, 2'd3, 6'd0);
      exp_q.push_back(item(1'b1, 1'b0, 2'd0, 32'hF0));
      exp_q.push_back(item(1'b0, 1'b1, 2'd3, 32'hF1));
      tick(4);
      compare_frames("t4");
      check_val("t4 drop_cnt", 64'(drop_cnt), ec(2));
      check_val("t4 frame_cnt", 64'(frame_cnt), ec(1));
      check_val("t4 hdr_word", 64'(hdr_word), STATS ? 64'hF0 : 64'd0);

      // Reset mid-frame with a committed frame queued.
      out_ready = 1'b0;
      send(32'h60, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'h61, 1'b0, 1'b1, 2'd0, 6'd0);
      check_val("t5 queued", 64'(out_valid), 64'd1);
      send(32'h70, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'h71, 1'b0, 1'b0, 2'd0, 6'd0);
      rst = 1'b0;
      #1;
      check_val("t5 reset out_valid", 64'(out_valid), 64'd0);
      check_val("t5 reset out_data", 64'(out_data), 64'd0);
      check_val("t5 reset out_sop/eop/mod", 64'({out_sop, out_eop, out_mod}), 64'd0);
      check_val("t5 reset rdy", 64'(ff_rx_rdy), 64'd1);
      check_val("t5 reset stats", 64'({frame_cnt, err_cnt, drop_cnt, hdr_word}), 64'd0);
      tick(2);
      rst       = 1'b1;
      out_ready = 1'b1;
      tick(1);
      send(32'h80, 1'b1, 1'b0, 2'd0, 6'd0);
      send(32'h81, 1'b0, 1'b0, 2'd0, 6'd0);
      send(32'h82, 1'b0, 1'b1, 2'd1, 6'd0);
      exp_q.push_back(item(1'b1, 1'b0, 2'd0, 32'h80));
      exp_q.push_back(item(1'b0, 1'b0, 2'd0, 32'h81));
      exp_q.push_back(item(1'b0, 1'b1, 2'd1, 32'h82));
      tick(6);
      compare_frames("t5");
      check_val("t5 frame_cnt", 64'(frame_cnt), ec(1));
      check_val("t5 hdr_word", 64'(hdr_word), STATS ? 64'h80 : 64'd0);

      // Saturation of a 4-bit counter, then clear winning over an increment.
      stats_clr = 1'b1;
      tick(1);
      stats_clr = 1'b0;
      for (int i = 0; i < 17; i++) begin
         send(32'h300 + 32'(i), 1'b1, 1'b1, 2'd0, 6'd0);
         exp_q.push_back(item(1'b1, 1'b1, 2'd0, 32'h300 + 32'(i)));
      end
      tick(4);
      compare_frames("t6");
      check_val("t6 frame_cnt saturated", 64'(frame_cnt), ec(15));
      stats_clr = 1'b1;
      send(32'h400, 1'b1, 1'b1, 2'd0, 6'd0);
      stats_clr = 1'b0;
      exp_q.push_back(item(1'b1, 1'b1, 2'd0, 32'h400));
      check_val("t6 clear beats increment", 64'(frame_cnt), 64'd0);
      check_val("t6 hdr_word kept", 64'(hdr_word), STATS ? 64'h400 : 64'd0);
      tick(3);
      compare_frames("t6b");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
